posit_fma_encoder: RTL and testbench
====================================

// Module: posit_fma_encoder
// PURPOSE
//  Back end of the posit FMA datapath. Accepts decomposed FMA results and packs them into an
//  N-bit posit: sign, signed scale factor, normalised 2N-bit mantissa, inf and zero flags.
//  Rounding is round-to-nearest-even with saturation, and negative results are two's-complemented.
//  Two-stage pipeline with valid/ready flow control between the FMA arithmetic stage and the PPU result bus.
// PARAMETERS
//  N   32          posit width
//  ES  2           exponent field width
//  RS  $clog2(N)   regime-count width; scale input is ES+RS+2 bits
// PORTS
//  clk        in   1         clock; all state on rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  in_valid   in   1         input fields valid
//  in_ready   out  1         encoder can accept this cycle
//  in_sign    in   1         result sign
//  in_scale   in   ES+RS+2   signed total scale = k*2^ES + e (two's complement)
//  in_mant    in   2N        normalised mantissa; hidden 1 at bit 2N-1
//  in_inf     in   1         result is NaR
//  in_zero    in   1         result is zero
//  out_valid  out  1         out_posit valid
//  out_ready  in   1         consumer accepts
//  out_posit  out  N         encoded posit
// BEHAVIOUR
//  - Reset (async, rst_n=0): s1_valid=0, s2_valid=0, out_valid=0, out_posit=0, in_ready=1.
//    A reset mid-operation discards all in-flight data.
//  - Handshake: a transfer occurs on a cycle with valid&ready. Latency is 2 cycles from input
//    accept to out_valid. Throughput is 1/cycle when out_ready=1.
//    in_ready = ~s1_valid | (~s2_valid | out_ready). No combinational path from in_valid to out_valid.
//  - While out_valid=1 and out_ready=0, out_posit and all pipeline registers hold.
//    A held output never changes until it is accepted.
//  - Stage 1 (register s1):
//    - k = in_scale >>> ES; e = in_scale[ES-1:0].
//    - Clamp k to [-(N-2), N-2]; the clamp sets a saturate flag.
//    - Regime: k>=0 gives k+1 ones then a 0; k<0 gives -k zeros then a 1.
//    - Build the unsigned magnitude string {0, regime, e, in_mant[2N-2:0]}.
//    - Shift it right into an N-bit field, capturing guard (first dropped bit) and
//      sticky (OR of all remaining dropped bits).
//  - Stage 2 (register s2 = output):
//    - RNE: add 1 if guard & (sticky | lsb).
//    - If the magnitude rounds to 0, force minpos (0..01).
//    - If it overflows past maxpos, force maxpos (01..1); the saturate flag also forces maxpos/minpos by k sign.
//    - Apply two's complement when sign=1.
//  - Priority: in_inf -> NaR (1 followed by N-1 zeros); else in_zero -> 0; else normal encode.
//    Sign is ignored for NaR and zero.
//  - Non-zero finite values never encode to 0 or NaR.
// CONFIGURATION
//  - POSIT_ENC_INEXACT_EN defined: add output port out_inexact (1 bit), aligned with out_posit.
//    It is 1 when guard|sticky was set or saturation occurred, 0 for NaR/zero, and 0 on reset.
//  - Not defined: no port and no extra flops; out_posit is unchanged.
// STRUCTURE
//  - posit_pkg: NAR(N), MAXPOS(N), MINPOS(N) constant functions; scale_t typedef (ES+RS+2 bits signed).
//  - Sub-module posit_round_rne: combinational; inputs {mag, guard, sticky}; outputs {rounded mag, ovf}.
//  - Pipeline control: two valid flops with shared stall logic in this module.
// TESTING (N=32, ES=2)
//  - sign=0, scale=0, mant=0x8000_0000_0000_0000 -> 0x4000_0000;
//    same with sign=1 -> 0xC000_0000; scale=1 -> 0x4800_0000.
//  - Tie cases:
//    - mant=0x8000_0008_0000_0000, scale 0 -> 0x4000_0000 (tie, round to even down).
//    - mant=0x8000_0018_0000_0000 -> 0x4000_0002 (tie, round up).
//  - Saturation:
//    - scale=+200 -> 0x7FFF_FFFF; scale=-200 -> 0x0000_0001.
//    - scale=-200 with sign=1 -> 0xFFFF_FFFF.
//  - inf=1 with zero=1 -> 0x8000_0000; zero=1 alone -> 0x0000_0000.
//  - Back-to-back stream of 8 inputs with out_ready toggled randomly -> all 8 outputs in order,
//    no loss or duplication, out_posit stable while stalled, in_ready=0 only when both stages are full and stalled.
//  - rst_n pulsed low with 2 items in flight -> out_valid=0 immediately; after release, next item
//    appears 2 cycles after accept.
//    With POSIT_ENC_INEXACT_EN: the tie-up case gives out_inexact=1; 1.0 gives 0.

Source files
------------

// File: rtl/posit_fma_encoder_pkg.sv
// -----------------------------------------------------------------------------
// posit_pkg
// Shared definitions for the posit FMA encoder back end.
//   P_N, P_ES, P_RS : default posit width, exponent field width, regime-count width
//   scale_t         : signed total scale factor (ES+RS+2 bits at the defaults)
//   NAR(n)          : Not-a-Real pattern, 1 followed by n-1 zeros
//   MAXPOS(n)       : largest positive posit, 0 followed by n-1 ones
//   MINPOS(n)       : smallest positive posit, 0..01
// The constant functions return 64-bit values; callers keep the low n bits.
// -----------------------------------------------------------------------------
package posit_pkg;

  localparam int P_N  = 32;
  localparam int P_ES = 2;
  localparam int P_RS = $clog2(P_N);

  typedef logic signed [P_ES+P_RS+1:0] scale_t;

  function automatic logic [63:0] NAR(input int n);
    return 64'd1 << (n - 1);
  endfunction

  function automatic logic [63:0] MAXPOS(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] MINPOS(input int n);
    return (n > 1) ? 64'd1 : 64'd0;
  endfunction

endpackage

// File: rtl/posit_fma_encoder_if.sv
// -----------------------------------------------------------------------------
// posit_fma_encoder_if
// Bundles the two valid/ready channels of the encoder.
//   in_*  : decomposed FMA result from the arithmetic stage (valid/ready)
//   out_* : encoded posit towards the PPU result bus (valid/ready)
// Modports:
//   master : the environment (drives in_* fields and out_ready)
//   slave  : the encoder (drives in_ready and out_* results)
// Optional feature macro: POSIT_ENC_INEXACT_EN adds out_inexact.
// -----------------------------------------------------------------------------
interface posit_fma_encoder_if #(
  parameter int N  = 32,
  parameter int ES = 2,
  parameter int RS = $clog2(N)
);

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_sign;
  logic [ES+RS+1:0]     in_scale;
  logic [2*N-1:0]       in_mant;
  logic                 in_inf;
  logic                 in_zero;
  logic                 out_valid;
  logic                 out_ready;
  logic [N-1:0]         out_posit;
`ifdef POSIT_ENC_INEXACT_EN
  logic                 out_inexact;
`endif

  modport master (
    output in_valid, in_sign, in_scale, in_mant, in_inf, in_zero, out_ready,
`ifdef POSIT_ENC_INEXACT_EN
    input  out_inexact,
`endif
    input  in_ready, out_valid, out_posit
  );

  modport slave (
    input  in_valid, in_sign, in_scale, in_mant, in_inf, in_zero, out_ready,
`ifdef POSIT_ENC_INEXACT_EN
    output out_inexact,
`endif
    output in_ready, out_valid, out_posit
  );

endinterface

// File: rtl/posit_fma_encoder_round.sv
// -----------------------------------------------------------------------------
// posit_round_rne
// Combinational round-to-nearest-even on an unsigned posit magnitude.
//   mag     in  N  magnitude (bit N-1 always 0)
//   guard   in  1  first dropped bit
//   sticky  in  1  OR of all further dropped bits
//   rounded out N  magnitude after rounding
//   ovf     out 1  rounding carried past maxpos into the sign position
// -----------------------------------------------------------------------------
module posit_round_rne #(
  parameter int N = 32
) (
  input  logic [N-1:0] mag,
  input  logic         guard,
  input  logic         sticky,
  output logic [N-1:0] rounded,
  output logic         ovf
);

  logic         round_up;
  logic [N:0]   sum;

  // Round up on more-than-half, or on an exact half when the kept lsb is odd.
  // Since the magnitude never uses bit N-1, a carry into it means the value
  // went past maxpos.
  always_comb begin
    round_up = guard & (sticky | mag[0]);
    sum      = {1'b0, mag} + {{N{1'b0}}, round_up};
    rounded  = sum[N-1:0];
    ovf      = sum[N] | sum[N-1];
  end

endmodule

// File: rtl/posit_fma_encoder.sv
// -----------------------------------------------------------------------------
// posit_fma_encoder
// Back end of the posit FMA datapath: packs sign / scale / normalised mantissa
// into an N-bit posit with round-to-nearest-even and saturation.
// Two register stages (s1: regime build + alignment, s2: rounding + sign),
// valid/ready on both sides, 2-cycle latency, 1 result/cycle when unstalled.
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset, discards in-flight data
//   bus    posit_fma_encoder_if.slave (in_* request channel, out_* result channel)
// Optional feature macro: POSIT_ENC_INEXACT_EN adds out_inexact aligned with
// out_posit; without it no extra flop exists.
// -----------------------------------------------------------------------------
module posit_fma_encoder
  import posit_pkg::*;
#(
  parameter int N  = P_N,
  parameter int ES = P_ES,
  parameter int RS = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  posit_fma_encoder_if.slave  bus
);

  localparam int SW = ES + RS + 2;
  localparam int TW = ES + 2*N - 1;
  localparam int W2 = 2 + TW + N;

  localparam logic signed [SW-1:0] K_MAX = SW'(N - 2);
  localparam logic signed [SW-1:0] K_MIN = SW'(-(N - 2));

  localparam logic [63:0]  NAR_W    = NAR(N);
  localparam logic [63:0]  MAXPOS_W = MAXPOS(N);
  localparam logic [63:0]  MINPOS_W = MINPOS(N);
  localparam logic [N-1:0] NAR_C    = NAR_W[N-1:0];
  localparam logic [N-1:0] MAXPOS_C = MAXPOS_W[N-1:0];
  localparam logic [N-1:0] MINPOS_C = MINPOS_W[N-1:0];

  logic                  s1_en;
  logic                  s2_en;

  logic signed [SW-1:0]  scale;
  logic signed [SW-1:0]  k_raw;
  logic signed [SW-1:0]  k_cl;
  logic                  k_neg;
  logic        [SW-1:0]  shamt;
  logic                  sat_d;
  logic signed [W2-1:0]  seed;
  logic signed [W2-1:0]  shifted;
  logic        [N-1:0]   mag_d;
  logic                  guard_d;
  logic                  sticky_d;
  logic                  unused_hidden;

  logic                  s1_valid;
  logic                  s1_sign;
  logic                  s1_inf;
  logic                  s1_zero;
  logic                  s1_sat;
  logic                  s1_kneg;
  logic        [N-1:0]   s1_mag;
  logic                  s1_guard;
  logic                  s1_sticky;

  logic        [N-1:0]   rounded;
  logic                  ovf;
  logic        [N-1:0]   enc;
  logic                  inexact_d;

  logic                  s2_valid;
  logic        [N-1:0]   s2_posit;

  // Shared stall logic: the output register may load when it is empty or being
  // drained; stage 1 may load when it is empty or can move into stage 2.
  always_comb begin
    s2_en = ~s2_valid | bus.out_ready;
    s1_en = ~s1_valid | s2_en;
  end

  assign bus.in_ready  = s1_en;
  assign bus.out_valid = s2_valid;
  assign bus.out_posit = s2_posit;

  // The hidden one of the normalised mantissa is implied by the regime
  // terminator, so bit 2N-1 carries no information here.
  assign unused_hidden = bus.in_mant[2*N-1];

  // Stage 1 datapath. The regime is produced by arithmetic-shifting a 2-bit
  // seed: "10" shifted by k yields k+1 ones then a zero, "01" shifted by -k-1
  // (= ~k) yields -k zeros then a one. The seed is padded with N zeros on the
  // right so no dropped bit is lost before guard/sticky are extracted.
  always_comb begin
    scale = $signed(bus.in_scale);
    k_raw = scale >>> ES;
    sat_d = 1'b0;
    k_cl  = k_raw;
    if (k_raw > K_MAX) begin
      k_cl  = K_MAX;
      sat_d = 1'b1;
    end else if (k_raw < K_MIN) begin
      k_cl  = K_MIN;
      sat_d = 1'b1;
    end
    k_neg    = k_cl[SW-1];
    shamt    = k_neg ? ~k_cl : k_cl;
    seed     = {(k_neg ? 2'b01 : 2'b10), bus.in_scale[ES-1:0],
                bus.in_mant[2*N-2:0], {N{1'b0}}};
    shifted  = seed >>> shamt;
    mag_d    = {1'b0, shifted[W2-1 -: N-1]};
    guard_d  = shifted[W2-N];
    sticky_d = |shifted[W2-N-1:0];
  end

  // Stage 1 register: captures a new request whenever stage 1 is free to move,
  // otherwise everything holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_inf    <= 1'b0;
      s1_zero   <= 1'b0;
      s1_sat    <= 1'b0;
      s1_kneg   <= 1'b0;
      s1_mag    <= '0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign   <= bus.in_sign;
        s1_inf    <= bus.in_inf;
        s1_zero   <= bus.in_zero;
        s1_sat    <= sat_d;
        s1_kneg   <= k_neg;
        s1_mag    <= mag_d;
        s1_guard  <= guard_d;
        s1_sticky <= sticky_d;
      end
    end
  end

  posit_round_rne #(.N(N)) u_round (
    .mag     (s1_mag),
    .guard   (s1_guard),
    .sticky  (s1_sticky),
    .rounded (rounded),
    .ovf     (ovf)
  );

  // Stage 2 encode: saturation and overflow clamp to maxpos/minpos so a finite
  // non-zero value never becomes 0 or NaR; negation happens after clamping.
  // NaR outranks zero, and both ignore the sign.
  always_comb begin
    enc = rounded;
    if (s1_sat) begin
      enc = s1_kneg ? MINPOS_C : MAXPOS_C;
    end else if (ovf) begin
      enc = MAXPOS_C;
    end else if (rounded == '0) begin
      enc = MINPOS_C;
    end
    if (s1_sign) begin
      enc = -enc;
    end
    if (s1_inf) begin
      enc = NAR_C;
    end else if (s1_zero) begin
      enc = '0;
    end
    inexact_d = ~(s1_inf | s1_zero) & (s1_guard | s1_sticky | s1_sat);
  end

  // Output register: only advances when empty or accepted, so a stalled
  // result stays put until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_posit <= '0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_posit <= enc;
      end
    end
  end

`ifdef POSIT_ENC_INEXACT_EN
  logic s2_inexact;

  // Inexact flag travels alongside out_posit with the same enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_inexact <= 1'b0;
    end else if (s2_en && s1_valid) begin
      s2_inexact <= inexact_d;
    end
  end

  assign bus.out_inexact = s2_inexact;
`else
  logic unused_inexact;
  assign unused_inexact = inexact_d;
`endif

endmodule

// File: tb/tb_posit_fma_encoder.sv
// -----------------------------------------------------------------------------
// tb_posit_fma_encoder
// Self-checking bench for posit_fma_encoder (N=32, ES=2). Expected results are
// queued when a request is driven and compared when the encoder delivers.
// Honours POSIT_ENC_INEXACT_EN by also checking out_inexact.
// -----------------------------------------------------------------------------
module tb_posit_fma_encoder;
  import posit_pkg::*;

  typedef struct packed {
    logic [31:0] posit;
    logic        inexact;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  int checks   = 0;
  int failures = 0;
  int inflight = 0;
  int got_out  = 0;

  exp_t exp_q[$];

  logic        held_valid = 1'b0;
  logic [31:0] held_posit;
  logic        rand_ready = 1'b0;

  posit_fma_encoder_if #(.N(32), .ES(2)) bus ();

  posit_fma_encoder #(.N(32), .ES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Independent bit-serial reference encoder: writes sign, regime, exponent
  // and fraction one bit at a time, then rounds the first 32 bits.
  function automatic logic [32:0] model_encode(input logic sign, input scale_t scale,
                                               input logic [63:0] mant,
                                               input logic inf, input logic zero);
    logic [127:0] s;
    logic [31:0]  mag;
    logic [31:0]  r;
    logic         g;
    logic         st;
    logic         sat;
    int           k;
    int           p;
    if (inf) return {1'b0, 32'h8000_0000};
    if (zero) return 33'd0;
    k   = int'(scale) >>> 2;
    sat = 1'b0;
    if (k > 30) begin k = 30; sat = 1'b1; end
    if (k < -30) begin k = -30; sat = 1'b1; end
    s = '0;
    p = 126;
    if (k >= 0) begin
      for (int i = 0; i <= k; i++) begin s[7'(p)] = 1'b1; p--; end
      s[7'(p)] = 1'b0; p--;
    end else begin
      for (int i = 0; i < -k; i++) begin s[7'(p)] = 1'b0; p--; end
      s[7'(p)] = 1'b1; p--;
    end
    s[7'(p)] = scale[1]; p--;
    s[7'(p)] = scale[0]; p--;
    for (int i = 62; i >= 0; i--) begin s[7'(p)] = mant[6'(i)]; p--; end
    mag = s[127:96];
    g   = s[95];
    st  = |s[94:0];
    r   = mag + {31'd0, g & (st | mag[0])};
    if (sat) r = (k > 0) ? 32'h7FFF_FFFF : 32'h0000_0001;
    else if (r[31]) r = 32'h7FFF_FFFF;
    else if (r == 32'd0) r = 32'h0000_0001;
    if (sign) r = -r;
    return {g | st | sat, r};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives one request (called at posedge+1), queues its expected result and
  // returns at posedge+1 of the accepting edge.
  task automatic apply_stimulus(input logic sign, input scale_t scale,
                                input logic [63:0] mant, input logic inf,
                                input logic zero, input logic [31:0] exp_posit,
                                input logic exp_inexact);
    bit accepted = 0;
    bus.in_sign  = sign;
    bus.in_scale = scale;
    bus.in_mant  = mant;
    bus.in_inf   = inf;
    bus.in_zero  = zero;
    bus.in_valid = 1'b1;
    exp_q.push_back('{posit: exp_posit, inexact: exp_inexact});
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        accepted = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (!accepted) begin
      checks++;
      failures++;
      $error("[TB] FAIL accept_timeout observed=0 expected=1");
    end
  endtask

  task automatic apply_model(input logic sign, input scale_t scale, input logic [63:0] mant);
    logic [32:0] m;
    m = model_encode(sign, scale, mant, 1'b0, 1'b0);
    apply_stimulus(sign, scale, mant, 1'b0, 1'b0, m[31:0], m[32]);
  endtask

  // Random back-pressure on the result bus when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: scoreboard compare on every output handshake, hold check while
  // stalled, and in_ready checked against the number of items in flight.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_valid = 1'b0;
      end else begin
        check_output("in_ready", {31'd0, bus.in_ready},
                     {31'd0, !(inflight == 2 && !bus.out_ready)});
        if (bus.out_valid && held_valid)
          check_output("held_posit", bus.out_posit, held_posit);
        if (bus.out_valid && bus.out_ready) begin
          got_out++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL unexpected_output observed=%h expected=none", bus.out_posit);
          end else begin
            e = exp_q.pop_front();
            check_output("out_posit", bus.out_posit, e.posit);
`ifdef POSIT_ENC_INEXACT_EN
            check_output("out_inexact", {31'd0, bus.out_inexact}, {31'd0, e.inexact});
`endif
          end
        end
        held_valid = bus.out_valid && !bus.out_ready;
        held_posit = bus.out_posit;
        inflight = inflight + int'(bus.in_valid && bus.in_ready)
                            - int'(bus.out_valid && bus.out_ready);
      end
    end
  end

  task automatic wait_drain();
    bit done = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && inflight == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $error("[TB] FAIL drain_timeout observed=%0d expected=0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sign  = 1'b0;
    bus.in_scale = '0;
    bus.in_mant  = '0;
    bus.in_inf   = 1'b0;
    bus.in_zero  = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    $display("[TB] reset state");
    check_output("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_output("rst_out_posit", bus.out_posit, 32'd0);
    check_output("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
`ifdef POSIT_ENC_INEXACT_EN
    check_output("rst_out_inexact", {31'd0, bus.out_inexact}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    apply_stimulus(0,  9'sd0,    64'h8000_0000_0000_0000, 0, 0, 32'h4000_0000, 0);
    apply_stimulus(1,  9'sd0,    64'h8000_0000_0000_0000, 0, 0, 32'hC000_0000, 0);
    apply_stimulus(0,  9'sd1,    64'h8000_0000_0000_0000, 0, 0, 32'h4800_0000, 0);
    apply_stimulus(0,  9'sd0,    64'h8000_0008_0000_0000, 0, 0, 32'h4000_0000, 1);
    apply_stimulus(0,  9'sd0,    64'h8000_0018_0000_0000, 0, 0, 32'h4000_0002, 1);
    apply_stimulus(0,  9'sd200,  64'h8000_0000_0000_0000, 0, 0, 32'h7FFF_FFFF, 1);
    apply_stimulus(0, -9'sd200,  64'h8000_0000_0000_0000, 0, 0, 32'h0000_0001, 1);
    apply_stimulus(1, -9'sd200,  64'h8000_0000_0000_0000, 0, 0, 32'hFFFF_FFFF, 1);
    apply_stimulus(0,  9'sd0,    64'h8000_0000_0000_0000, 1, 1, 32'h8000_0000, 0);
    apply_stimulus(0,  9'sd0,    64'h8000_0000_0000_0000, 0, 1, 32'h0000_0000, 0);
    apply_stimulus(1,  9'sd5,    64'hC000_0000_0000_0000, 1, 0, 32'h8000_0000, 0);
    apply_stimulus(1,  9'sd5,    64'hC000_0000_0000_0000, 0, 1, 32'h0000_0000, 0);
    apply_stimulus(0, -9'sd1,    64'h8000_0000_0000_0000, 0, 0, 32'h3800_0000, 0);
    apply_stimulus(0,  9'sd4,    64'h8000_0000_0000_0000, 0, 0, 32'h6000_0000, 0);
    apply_stimulus(0, -9'sd4,    64'h8000_0000_0000_0000, 0, 0, 32'h2000_0000, 0);
    wait_drain();

    $display("[TB] random stream with back-pressure");
    rand_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      apply_model(1'($urandom_range(0, 1)), scale_t'($urandom_range(0, 511)),
                  {1'b1, 31'($urandom), 32'($urandom)});
    end
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain();

    $display("[TB] reset with items in flight");
    bus.out_ready = 1'b0;
    apply_model(0, 9'sd3, 64'h9000_0000_0000_0000);
    apply_model(1, 9'sd7, 64'hA000_0000_0000_0000);
    rst_n = 1'b0;
    #1;
    check_output("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_output("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    exp_q.delete();
    inflight = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(0, 9'sd1, 64'h8000_0000_0000_0000, 0, 0, 32'h4800_0000, 0);
    @(negedge clk);
    check_output("latency_cycle1", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    check_output("latency_cycle2", {31'd0, bus.out_valid}, 32'd1);
    wait_drain();

    check_output("outputs_seen", got_out, 32'd24);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
